// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program counter / fetch sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  localparam int unsigned D_DEF        = 12;
  localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO for the program counter; a push when full drops the oldest entry.
module call_stack #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  // Entry 0 is the top; shifting towards higher indices pushes the oldest off the end.
  // NOTE: storage has no reset; validity is tracked by cnt_q alone, so entries never need clearing.
  always_ff @(posedge clk) begin
    if (push_i) begin
      for (int i = DEPTH - 1; i > 0; i--) mem_q[i] <= mem_q[i-1];
      mem_q[0] <= push_data_i;
    end else if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                                  cnt_d = '0;
    else if (push_i && cnt_q != CW'(DEPTH))       cnt_d = cnt_q + CW'(1);
    else if (pop_i && cnt_q != '0)                cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign top_o   = mem_q[0];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/prog_counter.sv
// Program counter and run/halt FSM; steps by +1 or a LUT-supplied relative target.
// Define PC_CALLSTK_EN to add the call/return stack and the stk_err flag.
module prog_counter
  import pc_pkg::*;
#(
  parameter int unsigned D         = D_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [1:0]   branch_sel,
  output logic [1:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  input  logic         call_en,
  input  logic         ret_en,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic         stk_err
);

  localparam logic [D-1:0] START_PC = D'(RESET_PC);

  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         running_q, done_q;
  logic [D-1:0] pc_tgt;

  assign lut_addr = branch_sel;
  assign pc_tgt   = pc_q + lut_target;

`ifdef PC_CALLSTK_EN
  logic         stk_err_q, stk_err_d;
  logic         stk_push, stk_pop, stk_clear;
  logic [D-1:0] stk_top;
  logic         stk_full, stk_empty;

  call_stack #(.W(D), .DEPTH(STK_DEPTH)) u_call_stack (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (pc_q + D'(1)),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );
`else
  localparam int unsigned unused_stk_depth = STK_DEPTH;
  logic unused_ctl;
  assign unused_ctl = call_en ^ ret_en;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_CALLSTK_EN
    stk_err_d = stk_err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
`ifdef PC_CALLSTK_EN
          stk_err_d = 1'b0;
          stk_clear = 1'b1;
`endif
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = DONE;
        end else if (stall) begin
          pc_d = pc_q;
`ifdef PC_CALLSTK_EN
        end else if (ret_en) begin
          stk_pop = !stk_empty;
          if (stk_empty) begin
            pc_d      = START_PC;
            stk_err_d = 1'b1;
          end else begin
            pc_d = stk_top;
          end
        end else if (call_en) begin
          stk_push = 1'b1;
          pc_d     = pc_tgt;
          if (stk_full) stk_err_d = 1'b1;
`endif
        end else if (branch_en) begin
          pc_d = pc_tgt;
        end else begin
          pc_d = pc_q + D'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

`ifdef PC_CALLSTK_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stk_err_q <= 1'b0;
    else          stk_err_q <= stk_err_d;
  end
  assign stk_err = stk_err_q;
`else
  assign stk_err = 1'b0;
`endif

  assign pc      = pc_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios plus randomized run against a queue-based model.
module tb_prog_counter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start, halt_req, stall, branch_en, call_en, ret_en;
  logic [1:0]  branch_sel, lut_addr;
  logic [11:0] lut_target, pc;
  logic        running, done, stk_err;
  logic [11:0] lut_tbl [4];

  int total = 0;
  int bad   = 0;

  // Reference model: PC as an integer, run/done flags, return stack as a queue (back = top).
  int m_pc;
  bit m_run, m_done, m_err;
  int m_stk [$];

  always #5 Clk = ~Clk;

  assign lut_target = lut_tbl[lut_addr];

  prog_counter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_sel (branch_sel),
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .stk_err    (stk_err)
  );

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_done = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit st, hr, sl, br, ca, re, input logic [1:0] sel);
    int tgt_pc;
    tgt_pc = (m_pc + int'(lut_tbl[sel])) % 4096;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_done = 0; m_pc = 0; m_err = 0;
        m_stk.delete();
      end
    end else if (hr) begin
      m_run = 0; m_done = 1;
    end else if (sl) begin
      m_pc = m_pc;
`ifdef PC_CALLSTK_EN
    end else if (re) begin
      if (m_stk.size() == 0) begin
        m_pc = 0; m_err = 1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (ca) begin
      if (m_stk.size() == 4) begin
        void'(m_stk.pop_front());
        m_err = 1;
      end
      m_stk.push_back((m_pc + 1) % 4096);
      m_pc = tgt_pc;
`endif
    end else if (br) begin
      m_pc = tgt_pc;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic tick(input bit st, hr, sl, br, ca, re, input logic [1:0] sel);
    start = st; halt_req = hr; stall = sl; branch_en = br;
    call_en = ca; ret_en = re; branch_sel = sel;
    model_step(st, hr, sl, br, ca, re, sel);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic branch(input logic [1:0] sel, input logic [11:0] tgt);
    lut_tbl[sel] = tgt;
    tick(0, 0, 0, 1, 0, 0, sel);
  endtask

  task automatic restart();
    if (m_run) tick(0, 1, 0, 0, 0, 0, 2'd0);
    tick(1, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #12;
    total++;
    if ({pc, running, done, stk_err} !== {12'h000, 3'b000}) begin
      bad++; $display("FAIL reset_state pc=%0h run=%b done=%b err=%b expected 0/0/0/0", pc, running, done, stk_err);
    end
    @(negedge Clk); Reset_n = 1'b1;
    model_reset();
    branch(2'd1, 12'd7);
    total++;
    if ({pc, running} !== {12'h000, 1'b0}) begin
      bad++; $display("FAIL idle_ignores_branch pc=%0h run=%b expected 0/0", pc, running);
    end
    restart();
    repeat (7) idle_tick();
    total++;
    if (pc !== 12'd7) begin bad++; $display("FAIL pre_reset_pc pc=%0h expected 7", pc); end
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({pc, running, done} !== {12'h000, 2'b00}) begin
      bad++; $display("FAIL async_reset pc=%0h run=%b done=%b expected 0/0/0", pc, running, done);
    end
    model_reset();
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic test_count();
    tick(1, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i <= 5; i++) begin
      total++;
      if ({pc, running} !== {12'(i), 1'b1}) begin
        bad++; $display("FAIL count_%0d pc=%0h run=%b expected %0h/1", i, pc, running, i);
      end
      if (i < 5) idle_tick();
    end
    tick(1, 0, 0, 0, 0, 0, 2'd0);
    total++;
    if (pc !== 12'd6) begin bad++; $display("FAIL start_in_run pc=%0h expected 6", pc); end
  endtask

  task automatic test_branch();
    branch_sel = 2'd2;
    #1;
    total++;
    if (lut_addr !== 2'd2) begin bad++; $display("FAIL lut_addr got=%0d expected 2", lut_addr); end
    restart();
    repeat (4) idle_tick();
    branch(2'd1, 12'hFFF);
    total++;
    if (pc !== 12'd3) begin bad++; $display("FAIL br_minus1 pc=%0h expected 3", pc); end
    restart();
    branch(2'd2, 12'd30);
    branch(2'd3, 12'hFFB);
    total++;
    if (pc !== 12'd25) begin bad++; $display("FAIL br_minus5 pc=%0d expected 25", pc); end
    restart();
    idle_tick();
    branch(2'd0, 12'd20);
    total++;
    if (pc !== 12'd21) begin bad++; $display("FAIL br_plus20 pc=%0d expected 21", pc); end
    branch(2'd0, 12'd0);
    total++;
    if (pc !== 12'd21) begin bad++; $display("FAIL br_zero_spin pc=%0d expected 21", pc); end
  endtask

  task automatic test_wrap();
    restart();
    branch(2'd1, 12'hFFF);
    idle_tick();
    total++;
    if (pc !== 12'd0) begin bad++; $display("FAIL wrap_up pc=%0h expected 0", pc); end
    restart();
    repeat (2) idle_tick();
    branch(2'd3, 12'hFFB);
    total++;
    if (pc !== 12'hFFD) begin bad++; $display("FAIL wrap_down pc=%0h expected ffd", pc); end
  endtask

  task automatic test_stall_halt();
    restart();
    branch(2'd0, 12'd9);
    lut_tbl[0] = 12'd5;
    tick(0, 0, 1, 1, 0, 0, 2'd0);
    total++;
    if (pc !== 12'd9) begin bad++; $display("FAIL stall_branch pc=%0d expected 9", pc); end
    tick(0, 1, 1, 0, 0, 0, 2'd0);
    total++;
    if ({pc, running, done} !== {12'd9, 2'b01}) begin
      bad++; $display("FAIL halt_stall pc=%0d run=%b done=%b expected 9/0/1", pc, running, done);
    end
    tick(0, 0, 0, 1, 0, 0, 2'd0);
    total++;
    if ({pc, done} !== {12'd9, 1'b1}) begin
      bad++; $display("FAIL done_hold pc=%0d done=%b expected 9/1", pc, done);
    end
    tick(1, 0, 0, 0, 0, 0, 2'd0);
    total++;
    if ({pc, running, done} !== {12'd0, 2'b10}) begin
      bad++; $display("FAIL done_restart pc=%0d run=%b done=%b expected 0/1/0", pc, running, done);
    end
  endtask

  task automatic test_callstk();
    restart();
    branch(2'd0, 12'd10);
`ifdef PC_CALLSTK_EN
    lut_tbl[1] = 12'd20;
    tick(0, 0, 0, 0, 1, 0, 2'd1);
    total++;
    if (pc !== 12'd30) begin bad++; $display("FAIL call pc=%0d expected 30", pc); end
    tick(0, 0, 0, 0, 0, 1, 2'd0);
    total++;
    if (pc !== 12'd11) begin bad++; $display("FAIL ret pc=%0d expected 11", pc); end
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 0, 0, 1, 0, 2'd1);
      total++;
      if (stk_err !== (i == 5)) begin
        bad++; $display("FAIL call_depth_%0d stk_err=%b expected %b", i, stk_err, i == 5);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 1, 2'd0);
      total++;
      if ({pc, stk_err} !== {12'(m_pc), m_err}) begin
        bad++; $display("FAIL pop_%0d pc=%0d err=%b expected %0d/%b", i, pc, stk_err, m_pc, m_err);
      end
    end
    total++;
    if ({pc, stk_err} !== {12'd0, 1'b1}) begin
      bad++; $display("FAIL pop_empty pc=%0d err=%b expected 0/1", pc, stk_err);
    end
`else
    lut_tbl[1] = 12'd20;
    tick(0, 0, 0, 0, 1, 0, 2'd1);
    tick(0, 0, 0, 0, 0, 1, 2'd1);
    total++;
    if ({pc, stk_err} !== {12'd12, 1'b0}) begin
      bad++; $display("FAIL callret_ignored pc=%0d err=%b expected 12/0", pc, stk_err);
    end
`endif
  endtask

  task automatic test_random();
    restart();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) lut_tbl[k] = 12'($urandom);
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           2'($urandom));
      total++;
      if ({pc, running, done, stk_err} !== {12'(m_pc), m_run, m_done, m_err}) begin
        bad++;
        $display("FAIL random_%0d pc=%0h run=%b done=%b err=%b expected %0h/%b/%b/%b",
                 n, pc, running, done, stk_err, m_pc, m_run, m_done, m_err);
      end
    end
  endtask

  initial begin
    start = 0; halt_req = 0; stall = 0; branch_en = 0;
    call_en = 0; ret_en = 0; branch_sel = 2'd0;
    for (int k = 0; k < 4; k++) lut_tbl[k] = 12'd0;
    model_reset();
    test_reset();
    test_count();
    test_branch();
    test_wrap();
    test_stall_halt();
    test_callstk();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
